// File: rtl/seg_scan_master_pkg.sv
// Shared definitions for the seven-segment scan master: FSM encoding, segment
// table and default bus addresses, also used by the data-memory MMIO decode.
package seg_scan_master_pkg;

  localparam logic [31:0] SRC_ADDR_DEFAULT  = 32'h0000_07FC;
  localparam logic [31:0] DISP_ADDR_DEFAULT = 32'h4000_0010;

  // Wide enough for SCAN_DIV-1 with SCAN_DIV up to 2^20.
  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_DECODE,
    ST_WRITE
  } state_t;

  // Bit order {dp,g,f,e,d,c,b,a}, active-high, dp always off; index 15 leftmost.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [3:0] digit_to_an(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg_scan_master_hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_seg7
  import seg_scan_master_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_master.sv
// Bus master that periodically reads four hex digits from data memory and
// writes one multiplexed digit (anode + segments) per scan period to the display.
module seg_scan_master
  import seg_scan_master_pkg::*;
#(
  parameter logic [31:0] SRC_ADDR  = SRC_ADDR_DEFAULT,
  parameter logic [31:0] DISP_ADDR = DISP_ADDR_DEFAULT,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_grant,
  input  logic [31:0] i_ReadData,
  output logic        o_req,
  output logic [31:0] o_addr,
  output logic [31:0] o_WriteData,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_busy,
  output logic [1:0]  o_digit
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCAN_DIV - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      digit_reg;
  logic [7:0]       seg_reg;
  logic [7:0]       seg;
  logic             unused_hi;

  assign unused_hi = ^i_ReadData[31:16];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (digit_reg[4*o_digit +: 4]),
    .seg    (seg)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      digit_reg <= '0;
      seg_reg   <= '0;
      o_digit   <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE:   if (i_enable) cnt <= CNT_LOAD;
        ST_WAIT:   if (cnt != '0) cnt <= cnt - 1'b1;
        ST_READ:   if (i_grant) digit_reg <= i_ReadData[15:0];
        ST_DECODE: seg_reg <= seg;
        ST_WRITE: begin
          if (i_grant) begin
            o_digit <= o_digit + 2'd1;
            if (i_enable) cnt <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    o_req       = 1'b0;
    o_addr      = '0;
    o_WriteData = '0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    case (state)
      ST_IDLE: if (i_enable) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!i_enable)        state_next = ST_IDLE;
        else if (cnt == '0)   state_next = ST_READ;
      end
      ST_READ: begin
        o_req     = 1'b1;
        o_addr    = SRC_ADDR;
        o_MemRead = i_grant;
        if (i_grant) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = ST_WRITE;
      ST_WRITE: begin
        o_req       = 1'b1;
        o_addr      = DISP_ADDR;
        o_WriteData = {20'h0, digit_to_an(o_digit), seg_reg};
        o_MemWrite  = i_grant;
        // The access finishes regardless of i_enable; only the follow-on state depends on it.
        if (i_grant) state_next = i_enable ? ST_WAIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy = (state != ST_IDLE);

endmodule
